// File: rtl/ex_mem_wb.sv
// Execute, memory and write-back stages with the data memory.
// Optional taken-branch squash FSM is built when BRANCH_SQUASH_EN is defined.
module ex_mem_wb #(
  parameter int DATA_MEMORY_SIZE = 10,
  parameter int SHADOW           = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  npc_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [15:0] imm_in,
  input  logic [4:0]  rd_in,
  input  logic [5:0]  opcode_in,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data,
  output logic        pc_mux_ctrl,
  output logic [31:0] pc_jmp,
  output logic        flush
);

  localparam logic [5:0] OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,
                         OP_AND  = 6'd3,  OP_OR   = 6'd4,  OP_NOR  = 6'd5,
                         OP_XOR  = 6'd6,  OP_SLA  = 6'd7,  OP_SLL  = 6'd8,
                         OP_SRA  = 6'd9,  OP_SRL  = 6'd10, OP_ADDI = 6'd32,
                         OP_SUBI = 6'd33, OP_LD   = 6'd34, OP_ST   = 6'd35,
                         OP_BEZ  = 6'd36, OP_BNE  = 6'd37, OP_JMP  = 6'd38;

  localparam int CW    = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);
  localparam int DEPTH = 2 ** DATA_MEMORY_SIZE;

  typedef struct packed {
    logic [31:0] result;   // ALU result, or DMEM address for LD/ST
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        we;
    logic        mr;
    logic        mw;
    logic        taken;
    logic [9:0]  target;
  } exm_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } mwb_t;

  exm_t        ex_d, exm;
  mwb_t        mwb;
  logic        squash;
  logic [5:0]  op_eff;
  logic [31:0] simm;
  logic [DATA_MEMORY_SIZE-1:0] mem_addr;

  logic [31:0] dmem [DEPTH];

  assign simm     = {{16{imm_in[15]}}, imm_in};
  assign op_eff   = squash ? OP_NOP : opcode_in;
  assign mem_addr = exm.result[DATA_MEMORY_SIZE-1:0];

  // ---------------- execute ----------------
  always_comb begin
    ex_d        = '0;
    ex_d.rd     = rd_in;
    ex_d.target = npc_in + imm_in[9:0];
    case (op_eff)
      OP_ADD:  begin ex_d.result = a_in + b_in;                  ex_d.we = 1'b1; end
      OP_SUB:  begin ex_d.result = a_in - b_in;                  ex_d.we = 1'b1; end
      OP_AND:  begin ex_d.result = a_in & b_in;                  ex_d.we = 1'b1; end
      OP_OR:   begin ex_d.result = a_in | b_in;                  ex_d.we = 1'b1; end
      OP_NOR:  begin ex_d.result = ~(a_in | b_in);               ex_d.we = 1'b1; end
      OP_XOR:  begin ex_d.result = a_in ^ b_in;                  ex_d.we = 1'b1; end
      OP_SLA,
      OP_SLL:  begin ex_d.result = a_in << b_in[4:0];            ex_d.we = 1'b1; end
      OP_SRA:  begin ex_d.result = $signed(a_in) >>> b_in[4:0];  ex_d.we = 1'b1; end
      OP_SRL:  begin ex_d.result = a_in >> b_in[4:0];            ex_d.we = 1'b1; end
      OP_ADDI: begin ex_d.result = a_in + simm;                  ex_d.we = 1'b1; end
      OP_SUBI: begin ex_d.result = a_in - simm;                  ex_d.we = 1'b1; end
      OP_LD: begin
        ex_d.result = a_in + simm;
        ex_d.we     = 1'b1;
        ex_d.mr     = 1'b1;
      end
      // Stores use an absolute address taken straight from the immediate.
      OP_ST: begin
        ex_d.result = simm;
        ex_d.sdata  = a_in;
        ex_d.mw     = 1'b1;
      end
      OP_BEZ:  ex_d.taken = (a_in == 32'd0);
      OP_BNE:  ex_d.taken = (a_in != 32'd0);
      OP_JMP:  ex_d.taken = 1'b1;
      default: ;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      exm <= '0;
      mwb <= '0;
    end else begin
      exm      <= ex_d;
      mwb.rd   <= exm.rd;
      mwb.we   <= exm.we;
      mwb.data <= exm.mr ? dmem[mem_addr] : exm.result;
    end
  end

  // Gating with rst drops a store that is sitting in EX/MEM when reset hits.
  always_ff @(posedge clk) begin
    if (!rst && exm.mw)
      dmem[mem_addr] <= exm.sdata;
  end

  // ---------------- branch squash ----------------
`ifdef BRANCH_SQUASH_EN
  typedef enum logic {IDLE = 1'b0, SQUASH = 1'b1} sq_state_t;

  sq_state_t      state;
  logic [CW-1:0]  cnt;

  // ex_d.taken is already forced low while squashing, so shadow branches vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_d.taken && SHADOW > 0) begin
            state <= SQUASH;
            cnt   <= CW'(SHADOW);
          end
        end
        SQUASH: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign squash = (state == SQUASH);
  assign flush  = squash;
`else
  logic unused_cfg;
  assign unused_cfg = |CW'(SHADOW);
  assign squash     = 1'b0;
  assign flush      = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign pc_mux_ctrl = exm.taken;
  assign pc_jmp      = {22'b0, exm.target};
  assign reg_wr_en   = mwb.we;
  assign reg_wr_addr = mwb.rd;
  assign reg_wr_data = mwb.data;

endmodule

// File: tb/tb_ex_mem_wb.sv
// Randomized + directed bench for ex_mem_wb against an instruction-level model.
module tb_ex_mem_wb;

  localparam int SHADOW = 3;
`ifdef BRANCH_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  npc_in;
  logic [31:0] a_in, b_in;
  logic [15:0] imm_in;
  logic [4:0]  rd_in;
  logic [5:0]  opcode_in;
  logic        reg_wr_en;
  logic [4:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        pc_mux_ctrl;
  logic [31:0] pc_jmp;
  logic        flush;

  ex_mem_wb #(.DATA_MEMORY_SIZE(10), .SHADOW(SHADOW)) dut (
    .clk(clk), .rst(rst), .npc_in(npc_in), .a_in(a_in), .b_in(b_in),
    .imm_in(imm_in), .rd_in(rd_in), .opcode_in(opcode_in),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .pc_mux_ctrl(pc_mux_ctrl), .pc_jmp(pc_jmp), .flush(flush)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: memory image, shadow remaining, and the write-back owed next cycle.
  bit [31:0] mmem [int];
  int        sq_cnt = 0;
  bit        pw_v = 0, pw_known = 0;
  bit [4:0]  pw_rd = 0;
  bit [31:0] pw_d = 0;

  task automatic model_reset();
    sq_cnt = 0;
    pw_v   = 0;
  endtask

  // Issues one instruction for one cycle and checks everything due at that edge.
  task automatic run_instr(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] imm, input logic [4:0] rd, input logic [9:0] npc);
    bit        squashed, br, wv, known;
    bit [31:0] d, simm;
    int        addr, tgt;
    opcode_in = op; a_in = a; b_in = b; imm_in = imm; rd_in = rd; npc_in = npc;
    n_chk++;
    if (flush !== (sq_cnt > 0)) begin
      n_fail++;
      $display("FAIL flush op=%0d: got %b want %b", op, flush, (sq_cnt > 0));
    end
    squashed = SQ && (sq_cnt > 0);
    if (squashed) sq_cnt--;
    simm = {{16{imm[15]}}, imm};
    br = 0; wv = 0; known = 1; d = 0;
    if (!squashed) begin
      case (op)
        1:  begin d = a + b;               wv = 1; end
        2:  begin d = a - b;               wv = 1; end
        3:  begin d = a & b;               wv = 1; end
        4:  begin d = a | b;               wv = 1; end
        5:  begin d = ~(a | b);            wv = 1; end
        6:  begin d = a ^ b;               wv = 1; end
        7, 8: begin d = a << (b % 32);     wv = 1; end
        9:  begin d = $signed(a) >>> (b % 32); wv = 1; end
        10: begin d = a >> (b % 32);       wv = 1; end
        32: begin d = a + simm;            wv = 1; end
        33: begin d = a - simm;            wv = 1; end
        34: begin
          addr = int'((a + simm) % 1024);
          wv = 1;
          if (mmem.exists(addr)) d = mmem[addr];
          else known = 0;
        end
        35: mmem[int'(simm % 1024)] = a;
        36: br = (a == 0);
        37: br = (a != 0);
        38: br = 1;
        default: ;
      endcase
    end
    tgt = (int'(npc) + int'($signed(imm))) & 1023;
    if (br && SQ) sq_cnt = SHADOW;
    @(posedge clk); #1;
    n_chk++;
    if (pc_mux_ctrl !== br) begin
      n_fail++;
      $display("FAIL pc_mux_ctrl op=%0d: got %b want %b", op, pc_mux_ctrl, br);
    end
    if (br) begin
      n_chk++;
      if (pc_jmp !== 32'(tgt)) begin
        n_fail++;
        $display("FAIL pc_jmp: got %0d want %0d", pc_jmp, tgt);
      end
    end
    n_chk++;
    if (reg_wr_en !== pw_v) begin
      n_fail++;
      $display("FAIL reg_wr_en: got %b want %b", reg_wr_en, pw_v);
    end
    if (pw_v) begin
      n_chk++;
      if (reg_wr_addr !== pw_rd) begin
        n_fail++;
        $display("FAIL reg_wr_addr: got %0d want %0d", reg_wr_addr, pw_rd);
      end
      if (pw_known) begin
        n_chk++;
        if (reg_wr_data !== pw_d) begin
          n_fail++;
          $display("FAIL reg_wr_data: got %h want %h", reg_wr_data, pw_d);
        end
      end
    end
    pw_v = wv; pw_rd = rd; pw_d = d; pw_known = known;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) run_instr(6'd0, 32'd0, 32'd0, 16'd0, 5'd0, 10'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    opcode_in = 6'd38; a_in = 0; b_in = 0; imm_in = 16'd5; rd_in = 5'd1; npc_in = 10'd1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({reg_wr_en, reg_wr_addr, reg_wr_data, pc_mux_ctrl, pc_jmp, flush} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got en=%b addr=%0d data=%h pcm=%b jmp=%h flush=%b want all 0",
               reg_wr_en, reg_wr_addr, reg_wr_data, pc_mux_ctrl, pc_jmp, flush);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_alu();
    run_instr(6'd1, 32'd7, 32'hFFFF_FFFD, 16'd0, 5'd1, 10'd0);   // ADD 7 + -3
    run_instr(6'd9, 32'h8000_0000, 32'd4, 16'd0, 5'd2, 10'd0);   // SRA
    run_instr(6'd10, 32'h8000_0000, 32'd4, 16'd0, 5'd0, 10'd0);  // SRL, rd=0 still writes
    run_instr(6'd5, 32'h0F0F_0000, 32'h0000_00F0, 16'd0, 5'd3, 10'd0);
    run_instr(6'd7, 32'h0000_0003, 32'h0000_0021, 16'd0, 5'd4, 10'd0);
    run_instr(6'd20, 32'd9, 32'd9, 16'd0, 5'd5, 10'd0);          // undefined op = NOP
    nop(2);
  endtask

  task automatic test_imm();
    run_instr(6'd33, 32'd5, 32'd0, 16'hFFFF, 5'd6, 10'd0);       // SUBI 5 - (-1)
    run_instr(6'd32, 32'h7FFF_FFFF, 32'd0, 16'd1, 5'd7, 10'd0);  // ADDI wraps
    nop(2);
  endtask

  task automatic test_mem();
    run_instr(6'd35, 32'hDEAD_BEEF, 32'd0, 16'h0010, 5'd9, 10'd0);  // ST, no write-back
    run_instr(6'd34, 32'h10, 32'd0, 16'd0, 5'd8, 10'd0);            // LD right behind it
    run_instr(6'd34, 32'hFFFF_F410, 32'd0, 16'd0, 5'd8, 10'd0);     // upper address bits ignored
    nop(2);
  endtask

  task automatic test_branch();
    run_instr(6'd36, 32'd0, 32'd0, 16'hFFEC, 5'd0, 10'd100);  // BEZ taken -> 80
    nop(SHADOW);
    run_instr(6'd37, 32'd0, 32'd0, 16'd4, 5'd0, 10'd100);     // BNE not taken
    run_instr(6'd37, 32'd5, 32'd0, 16'd4, 5'd0, 10'd1022);    // BNE taken, target wraps
    nop(SHADOW + 2);
  endtask

  task automatic test_squash();
    run_instr(6'd38, 32'd0, 32'd0, 16'd5, 5'd0, 10'd50);
    for (int i = 1; i <= 4; i++)
      run_instr(6'd1, 32'(i), 32'd100, 16'd0, 5'(i + 10), 10'd51);
    // JMP then a JMP in the shadow: discarded with squash, own pulse without.
    run_instr(6'd38, 32'd0, 32'd0, 16'd7, 5'd0, 10'd200);
    run_instr(6'd38, 32'd0, 32'd0, 16'd9, 5'd0, 10'd201);
    nop(SHADOW + 2);
  endtask

  task automatic test_reset_mid();
    run_instr(6'd35, 32'h1111_1111, 32'd0, 16'h0020, 5'd0, 10'd0);
    nop(2);
    run_instr(6'd1, 32'd40, 32'd2, 16'd0, 5'd12, 10'd0);
    // Hand-driven ST that must be dropped by the following reset.
    opcode_in = 6'd35; a_in = 32'h2222_2222; b_in = 0; imm_in = 16'h0020; rd_in = 0;
    @(posedge clk); #1;
    n_chk++;
    if (reg_wr_en !== 1'b1 || reg_wr_data !== 32'd42) begin
      n_fail++;
      $display("FAIL pre-reset add wb: got en=%b data=%0d want 1/42", reg_wr_en, reg_wr_data);
    end
    rst = 1'b1; opcode_in = 6'd0; a_in = 0; imm_in = 0;
    @(posedge clk); #1;
    n_chk++;
    if ({pc_mux_ctrl, reg_wr_en, flush} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid reset st: got pcm=%b en=%b flush=%b want 000", pc_mux_ctrl, reg_wr_en, flush);
    end
    rst = 1'b0;
    model_reset();
    run_instr(6'd34, 32'h20, 32'd0, 16'd0, 5'd3, 10'd0);  // old value survives
    nop(1);
    // Reset with a redirect pending and the squash machine running.
    run_instr(6'd38, 32'd0, 32'd0, 16'd3, 5'd0, 10'd10);
    rst = 1'b1; opcode_in = 6'd36; a_in = 0; imm_in = 16'd1; npc_in = 10'd11;
    @(posedge clk); #1;
    n_chk++;
    if ({pc_mux_ctrl, reg_wr_en, flush} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid reset br: got pcm=%b en=%b flush=%b want 000", pc_mux_ctrl, reg_wr_en, flush);
    end
    rst = 1'b0;
    model_reset();
    nop(2);
  endtask

  task automatic test_random();
    logic [5:0]  ops [22];
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [15:0] imm;
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd11, 6'd39, 6'd63, 6'd34};
    for (int i = 0; i < 400; i++) begin
      op  = ops[$urandom_range(0, 21)];
      a   = $urandom;
      b   = (op >= 6'd32) ? 32'd0 : $urandom;
      imm = 16'($urandom);
      if (op == 6'd35) imm = 16'($urandom_range(0, 15));
      if (op == 6'd34) begin a = 32'($urandom_range(0, 15)); imm = 16'd0; end
      if (op == 6'd36 || op == 6'd37) a = 32'($urandom_range(0, 1));
      run_instr(op, a, b, imm, 5'($urandom), 10'($urandom));
    end
    nop(SHADOW + 2);
  endtask

  initial begin
    rst = 1'b1; opcode_in = 0; a_in = 0; b_in = 0; imm_in = 0; rd_in = 0; npc_in = 0;
    test_reset();
    test_alu();
    test_imm();
    test_mem();
    test_branch();
    test_squash();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb.md
# ex_mem_wb

Back half of the 5-stage pipeline: it takes the decoded operand bundle driven by the ID/EX stage and runs the execute, memory and write-back stages. It owns the 1024×32 data memory. It returns register-file write requests (`reg_wr_*`) to ID/EX and branch/jump redirects (`pc_mux_ctrl`/`pc_jmp`) to IF/ID, closing both feedback loops of the core.

## Interface
Parameters:
- `DATA_MEMORY_SIZE`, default 10: log2 of the data-memory depth in words.
- `SHADOW`, default 3: number of instructions squashed after a taken branch (used only when squash is compiled in).

Ports:
- `clk` in 1: single clock. Everything is posedge.
- `rst` in 1: synchronous, active-high reset.
- `npc_in` in 10: PC+1 of the incoming instruction.
- `a_in` in 32: signed rs1 value.
- `b_in` in 32: signed rs2 value. Zero for opcodes ≥ 32.
- `imm_in` in 16: signed immediate.
- `rd_in` in 5: destination register / store-data selector.
- `opcode_in` in 6: instruction opcode.
- `reg_wr_en` out 1: register-file write strobe.
- `reg_wr_addr` out 5: write address.
- `reg_wr_data` out 32: write data.
- `pc_mux_ctrl` out 1: one-cycle redirect pulse to IF.
- `pc_jmp` out 32: redirect target, `{22'b0, target[9:0]}`.
- `flush` out 1: high on every cycle in which an incoming instruction is being squashed.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, NOR=5, XOR=6, SLA=7, SLL=8, SRA=9, SRL=10, ADDI=32, SUBI=33, LD=34, ST=35, BEZ=36, BNE=37, JMP=38. All other opcodes execute as NOP.
- Immediate: sign-extended to 32 bits (`simm`).
- Arithmetic: 32-bit, two's-complement wrap, no flags.
- ALU results:
  - NOR = ~(A|B).
  - SLA and SLL = A << B[4:0].
  - SRA = A >>> B[4:0] (arithmetic).
  - SRL = A >> B[4:0] (logical).
  - ADDI = A + simm.
  - SUBI = A − simm.
- LD: reads `DMEM[(A+simm)[9:0]]`; the upper address bits are ignored.
- ST: writes A to `DMEM[simm[9:0]]` (absolute address). Writes no register.
- Branch conditions:
  - BEZ is taken when A == 0.
  - BNE is taken when A != 0.
  - JMP is always taken.
- Branch target for all three is `(npc_in + imm_in[9:0]) mod 1024`. Branches and jumps write no register.
- Register writeback: R-type ops, ADDI, SUBI and LD write `rd_in`, including rd=0 (R0 is not hardwired to zero).
- Pipeline registers:
  - EX/MEM holds: result, store data, rd, write-enable, mem-read, mem-write, taken, target.
  - MEM/WB holds: rd, write-enable, and the selected data (ALU result or DMEM read).
- Squash state machine, states IDLE and SQUASH:
  - A taken branch captured into EX/MEM loads the counter with `SHADOW` and moves to SQUASH.
  - In SQUASH, each incoming instruction is replaced by NOP at EX capture, and the counter decrements.
  - When the count reaches 0, the machine returns to IDLE.
  - A branch arriving while squashed is discarded.
- DMEM is not reset; its contents are undefined until written.

## Timing
- Reset values: all pipeline registers hold NOP with enables low; the counter is 0 and the state is IDLE. All outputs are 0 in the cycle after `rst` is sampled high.
- Execute capture: inputs are sampled at edge E1 into EX/MEM.
- Redirect:
  - `pc_mux_ctrl` and `pc_jmp` are driven combinationally from EX/MEM during cycle E1→E2.
  - The pulse is exactly one cycle per taken branch.
- Memory access:
  - ST writes DMEM at E2.
  - LD reads DMEM synchronously at E2 into MEM/WB.
- Writeback: `reg_wr_*` are valid during E2→E3, so ID/EX commits the register at E3. Total latency is 2 cycles.
- Back-to-back hazards: the block does no forwarding. A dependent instruction must trail its producer by enough instructions to clear the register-file write.
- ST followed by LD to the same address on the next cycle: the LD returns the new data. Ordering is preserved because the store commits at the LD's E1.
- Reset mid-operation:
  - A pending ST in EX/MEM is dropped (DMEM is not written).
  - Any pending redirect is cancelled.
  - The squash counter is cleared.

## Configuration
- `BRANCH_SQUASH_EN` defined: the squash FSM and `flush` are built as described under Operation.
- `BRANCH_SQUASH_EN` undefined:
  - The FSM is removed and `flush` is tied to 0.
  - The instructions following a branch execute normally (delay-slot semantics).
  - A second taken branch in the shadow produces its own redirect pulse, and the later pulse wins at IF.

## Test plan
- ALU: ADD with A=7, B=−3 → `reg_wr_data`=4 two cycles later. SRA with A=0x80000000, B=4 → 0xF8000000. SRL with the same operands → 0x08000000.
- Immediate: SUBI with A=5, imm=0xFFFF → 6. ADDI with A=0x7FFFFFFF, imm=1 → 0x80000000 (wraps, no flag).
- Memory: ST A=0xDEADBEEF, imm=0x0010, then LD A=0x10, imm=0 on the next cycle → `reg_wr_data`=0xDEADBEEF and `reg_wr_en`=1. The ST itself never asserts `reg_wr_en`.
- Branch: BEZ with A=0, npc=100, imm=−20 → `pc_mux_ctrl`=1 for one cycle with `pc_jmp`=80. BNE with A=0 → no pulse.
- Squash (macro on):
  - JMP followed by three ADDs → `flush`=1 for 3 cycles, no `reg_wr_en` for those ADDs, and the 4th ADD writes.
  - With the macro off, the same sequence makes all three ADDs write.
- Reset: assert `rst` in the cycle after an ST is captured → DMEM location unchanged, and `pc_mux_ctrl`, `reg_wr_en` and `flush` are all 0 on the next cycle.
